// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for a single-issue pipeline.
//
// Issues at most one instruction-memory request at a time, registers the
// returned word for decode, and flushes on redirects (taken branch/jal/jalr).
// A response that belongs to a flushed request is discarded, whether it
// arrives in the redirect cycle (back to fetch) or later (drop state).
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : a redirect to an address with [1:0] != 0 raises misalign_o and
//               halts fetch until an aligned redirect or reset.
//   undefined : redirect targets are forced word-aligned, misalign_o stays 0.
//
// Ports:
//   clk, reset (sync, active-low)
//   stall_i, redirect_i, redirect_pc_i     - control from decode/execute
//   imem_req_o, imem_addr_o                - request pulse and address
//   imem_valid_i, imem_rdata_i, imem_rsp_ready_o - response handshake
//   instr_o, opcode_o, pc_o, pc_plus4_o, valid_o - registered decode payload
//   misalign_o                             - misaligned redirect flag
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        imem_rsp_ready_o,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {StReq, StWait, StDrop, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] redir_pc;
  logic        redir_bad;
  logic        rsp_ready;
  logic        load;

`ifdef MISALIGN_TRAP_EN
  assign redir_pc  = redirect_pc_i;
  assign redir_bad = redirect_pc_i[1:0] != 2'b00;
`else
  assign redir_pc  = redirect_pc_i & 32'hFFFF_FFFC;
  assign redir_bad = 1'b0;
`endif

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    load       = 1'b0;
    unique case (state_q)
      StReq: begin
        if (redirect_i) begin
          pc_d       = redir_pc;
          misalign_d = redir_bad;
          state_d    = redir_bad ? StHalt : StReq;
        end else if (!(valid_q && stall_i)) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_i) begin
          pc_d       = redir_pc;
          misalign_d = redir_bad;
          // Without the response in hand it is still outstanding: drop it first
          // even when heading for halt, so a later aligned redirect cannot
          // mistake it for its own.
          if (!imem_valid_i) state_d = StDrop;
          else               state_d = redir_bad ? StHalt : StReq;
        end else if (imem_valid_i && rsp_ready) begin
          load    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = StReq;
        end
      end
      StDrop: begin
        if (redirect_i) begin
          pc_d       = redir_pc;
          misalign_d = redir_bad;
        end
        if (imem_valid_i) state_d = misalign_d ? StHalt : StReq;
      end
      StHalt: begin
        if (redirect_i) begin
          pc_d       = redir_pc;
          misalign_d = redir_bad;
          state_d    = redir_bad ? StHalt : StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // Output register next-state: redirect beats load beats stall
  always_comb begin
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (redirect_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      instr_d  = imem_rdata_i;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
    end else if (!stall_i) begin
      valid_d = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    rsp_ready = 1'b0;
    unique case (state_q)
      StWait:         rsp_ready = redirect_i || !valid_q || !stall_i;
      StDrop, StHalt: rsp_ready = 1'b1;
      default:        rsp_ready = 1'b0;
    endcase
    imem_req_o       = reset && (state_q == StReq) && !redirect_i && !(valid_q && stall_i);
    imem_rsp_ready_o = reset && rsp_ready;
  end

  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign opcode_o    = valid_q ? instr_q[6:0] : 7'h00;
  assign pc_o        = pc_out_q;
  assign pc_plus4_o  = pc_out_q + 32'd4;
  assign valid_o     = valid_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_rsp_ready_o;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_valid_i     (imem_valid_i),
    .imem_rdata_i     (imem_rdata_i),
    .imem_rsp_ready_o (imem_rsp_ready_o),
    .instr_o          (instr_o),
    .opcode_o         (opcode_o),
    .pc_o             (pc_o),
    .pc_plus4_o       (pc_plus4_o),
    .valid_o          (valid_o),
    .misalign_o       (misalign_o)
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  // Memory model: one response per request, mem_lat cycles after the request
  int          mem_lat = 1;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_dly = 0;
  logic        force_en = 1'b0;
  logic [31:0] force_word = '0;

  // Values sampled at the negedge of the most recent step
  logic        last_req, last_valid, last_mis, last_rdy;
  logic [31:0] last_addr, last_pc, last_instr, last_pc4;
  logic [6:0]  last_op;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[26:2], a[2] ? 7'h33 : 7'h13};
  endfunction

  // One clock cycle: sample at negedge, consume to scoreboard, update memory after posedge
  task automatic step();
    logic        acc, req;
    logic [31:0] addr;
    exp_t        e;
    @(negedge clk);
    last_req = imem_req_o;   last_addr = imem_addr_o; last_valid = valid_o;
    last_pc  = pc_o;         last_instr = instr_o;    last_pc4 = pc_plus4_o;
    last_op  = opcode_o;     last_mis = misalign_o;   last_rdy = imem_rsp_ready_o;
    acc  = imem_valid_i && imem_rsp_ready_o;
    req  = imem_req_o;
    addr = imem_addr_o;
    if (reset && valid_o && !stall_i) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_extra: got pc %h instr %h, expected no instruction", pc_o, instr_o);
      end else begin
        e = exp_q.pop_front();
        if (pc_o !== e.pc || instr_o !== e.instr || opcode_o !== e.instr[6:0] ||
            pc_plus4_o !== e.pc + 32'd4) begin
          tests_failed++;
          $display("FAIL sb_word: got pc %h instr %h op %h pc4 %h, expected pc %h instr %h",
                   pc_o, instr_o, opcode_o, pc_plus4_o, e.pc, e.instr);
        end
      end
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      mem_pend     = 1'b0;
      imem_valid_i = 1'b0;
    end else begin
      if (acc) imem_valid_i = 1'b0;
      if (req) begin
        mem_pend = 1'b1;
        mem_addr = addr;
        mem_dly  = mem_lat - 1;
      end
      if (mem_pend) begin
        if (mem_dly == 0) begin
          imem_valid_i = 1'b1;
          imem_rdata_i = force_en ? force_word : word_at(mem_addr);
          mem_pend     = 1'b0;
        end else begin
          mem_dly--;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; force_en = 1'b0;
    step();
    step();
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: got %0d pending words, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    step();
    step();
    tests_run++;
    if (last_req !== 1'b0 || last_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake: got req %b rdy %b, expected 0 0", last_req, last_rdy);
    end
    tests_run++;
    if (last_valid !== 1'b0 || last_pc !== 32'h0 || last_instr !== 32'h0 || last_mis !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_regs: got valid %b pc %h instr %h mis %b, expected 0 0 0 0",
               last_valid, last_pc, last_instr, last_mis);
    end
    tests_run++;
    if (last_op !== 7'h00) begin
      tests_failed++;
      $display("FAIL reset_opcode: got %h expected 00", last_op);
    end
    reset = 1'b1;
    step();
    tests_run++;
    if (last_req !== 1'b1 || last_addr !== 32'h0040_0000) begin
      tests_failed++;
      $display("FAIL reset_first_req: got req %b addr %h, expected 1 00400000", last_req, last_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back({32'h0040_0000 + 32'(4 * i),
                                                 word_at(32'h0040_0000 + 32'(4 * i))});
    for (int c = 0; c <= 8; c++) begin
      step();
      exp_addr = 32'h0040_0000 + 32'(4 * (c / 2));
      tests_run++;
      if (last_req !== (c % 2 == 0) || (last_req && last_addr !== exp_addr)) begin
        tests_failed++;
        $display("FAIL seq_req c%0d: got req %b addr %h, expected req %b addr %h",
                 c, last_req, last_addr, c % 2 == 0, exp_addr);
      end
      tests_run++;
      if (last_valid !== (c >= 2 && c % 2 == 0)) begin
        tests_failed++;
        $display("FAIL seq_valid c%0d: got %b expected %b", c, last_valid, c >= 2 && c % 2 == 0);
      end
    end
    check_drained("seq");
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back({32'h0040_0000 + 32'(4 * i),
                                                 word_at(32'h0040_0000 + 32'(4 * i))});
    for (int c = 0; c < 4; c++) step();
    stall_i = 1'b1;
    for (int c = 4; c < 9; c++) begin
      step();
      tests_run++;
      if (last_req !== 1'b0 || last_valid !== 1'b1 || last_pc !== 32'h0040_0004 ||
          last_instr !== word_at(32'h0040_0004)) begin
        tests_failed++;
        $display("FAIL stall_hold c%0d: got req %b valid %b pc %h instr %h, expected 0 1 00400004 %h",
                 c, last_req, last_valid, last_pc, last_instr, word_at(32'h0040_0004));
      end
    end
    stall_i = 1'b0;
    step();
    tests_run++;
    if (last_req !== 1'b1 || last_addr !== 32'h0040_0008) begin
      tests_failed++;
      $display("FAIL stall_resume: got req %b addr %h, expected 1 00400008", last_req, last_addr);
    end
    step();
    step();
    check_drained("stall");
  endtask

  task automatic test_redirect_same();
    do_reset();
    exp_q.push_back({32'h0040_0100, word_at(32'h0040_0100)});
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0100;
    step();
    redirect_i = 1'b0;
    step();
    tests_run++;
    if (last_valid !== 1'b0 || last_req !== 1'b1 || last_addr !== 32'h0040_0100) begin
      tests_failed++;
      $display("FAIL redir_same: got valid %b req %b addr %h, expected 0 1 00400100",
               last_valid, last_req, last_addr);
    end
    step();
    step();
    check_drained("redir_same");
  endtask

  task automatic test_redirect_stall();
    do_reset();
    exp_q.push_back({32'h0040_0300, word_at(32'h0040_0300)});
    step();
    step();
    stall_i = 1'b1;
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0300;
    step();
    tests_run++;
    if (last_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_stall_noreq: got req %b expected 0", last_req);
    end
    redirect_i = 1'b0; stall_i = 1'b0;
    step();
    tests_run++;
    if (last_valid !== 1'b0 || last_req !== 1'b1 || last_addr !== 32'h0040_0300) begin
      tests_failed++;
      $display("FAIL redir_stall: got valid %b req %b addr %h, expected 0 1 00400300",
               last_valid, last_req, last_addr);
    end
    step();
    step();
    check_drained("redir_stall");
  endtask

  task automatic test_redirect_drop();
    mem_lat = 4;
    do_reset();
    exp_q.push_back({32'h0040_0180, word_at(32'h0040_0180)});
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0100;
    step();
    redirect_pc_i = 32'h0040_0180;
    step();
    redirect_i = 1'b0;
    step();
    tests_run++;
    if (last_req !== 1'b0 || last_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_wait: got req %b rdy %b, expected 0 1", last_req, last_rdy);
    end
    step();
    tests_run++;
    if (last_req !== 1'b0 || last_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_discard: got req %b valid %b, expected 0 0", last_req, last_valid);
    end
    step();
    tests_run++;
    if (last_req !== 1'b1 || last_addr !== 32'h0040_0180) begin
      tests_failed++;
      $display("FAIL drop_refetch: got req %b addr %h, expected 1 00400180", last_req, last_addr);
    end
    for (int c = 6; c < 10; c++) begin
      step();
      tests_run++;
      if (last_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL drop_late c%0d: got valid %b expected 0", c, last_valid);
      end
    end
    step();
    check_drained("drop");
    mem_lat = 1;
  endtask

  task automatic test_opcode();
    do_reset();
    force_en = 1'b1; force_word = 32'h00A0_0093;
    exp_q.push_back({32'h0040_0000, 32'h00A0_0093});
    step();
    step();
    tests_run++;
    if (last_valid !== 1'b0 || last_op !== 7'h00) begin
      tests_failed++;
      $display("FAIL opcode_idle: got valid %b op %h, expected 0 00", last_valid, last_op);
    end
    step();
    tests_run++;
    if (last_op !== 7'h13 || last_instr !== 32'h00A0_0093) begin
      tests_failed++;
      $display("FAIL opcode_live: got op %h instr %h, expected 13 00a00093", last_op, last_instr);
    end
    stall_i = 1'b1;
    step();
    step();
    check_drained("opcode");
    force_en = 1'b0;
  endtask

  task automatic test_misalign();
    do_reset();
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0102;
    step();
    redirect_i = 1'b0;
`ifdef MISALIGN_TRAP_EN
    for (int c = 2; c < 6; c++) begin
      step();
      tests_run++;
      if (last_mis !== 1'b1 || last_req !== 1'b0 || last_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL mis_halt c%0d: got mis %b req %b valid %b, expected 1 0 0",
                 c, last_mis, last_req, last_valid);
      end
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0200;
    step();
    redirect_i = 1'b0;
    exp_q.push_back({32'h0040_0200, word_at(32'h0040_0200)});
    step();
    tests_run++;
    if (last_mis !== 1'b0 || last_req !== 1'b1 || last_addr !== 32'h0040_0200) begin
      tests_failed++;
      $display("FAIL mis_exit: got mis %b req %b addr %h, expected 0 1 00400200",
               last_mis, last_req, last_addr);
    end
`else
    exp_q.push_back({32'h0040_0100, word_at(32'h0040_0100)});
    step();
    tests_run++;
    if (last_mis !== 1'b0 || last_req !== 1'b1 || last_addr !== 32'h0040_0100) begin
      tests_failed++;
      $display("FAIL mis_forced: got mis %b req %b addr %h, expected 0 1 00400100",
               last_mis, last_req, last_addr);
    end
`endif
    step();
    step();
    check_drained("misalign");
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    tests_run++;
    if (last_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_redir_noreq: got req %b expected 0", last_req);
    end
    redirect_i = 1'b0;
    exp_q.push_back({32'hFFFF_FFFC, word_at(32'hFFFF_FFFC)});
    exp_q.push_back({32'h0000_0000, word_at(32'h0000_0000)});
    step();
    tests_run++;
    if (last_req !== 1'b1 || last_addr !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_req: got req %b addr %h, expected 1 fffffffc", last_req, last_addr);
    end
    step();
    step();
    tests_run++;
    if (last_pc4 !== 32'h0 || last_req !== 1'b1 || last_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_pc: got pc4 %h req %b addr %h, expected 00000000 1 00000000",
               last_pc4, last_req, last_addr);
    end
    step();
    step();
    check_drained("wrap");
  endtask

  initial begin
    reset = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_valid_i = 1'b0; imem_rdata_i = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_same();
    test_redirect_stall();
    test_redirect_drop();
    test_opcode();
    test_misalign();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
